// File: rtl/mm_copr_pkg.sv
// mm_copr_pkg: FSM encodings and default widths shared by the coprocessor stream engines.
package mm_copr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
endpackage

// File: rtl/mm_skid_fifo.sv
// mm_skid_fifo: 2-entry FIFO that absorbs RAM read latency under accelerator backpressure.
module mm_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wp, rp, push, pop;

    assign empty = count == 2'd0;
    assign full  = count == 2'd2;
    assign push  = wr && (!full || rd);
    assign pop   = rd && !empty;
    assign rdata = mem[rp];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/mm_front_end.sv
// mm_front_end: streams SIZE tokens from the input buffer RAM to the accelerator port.
// Define MM_FE_BASE_ADDR_EN to add a base_addr input latched with start (reads wrap modulo 2^ADDR_W).
module mm_front_end
    import mm_copr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] size,
`ifdef MM_FE_BASE_ADDR_EN
    input  logic [ADDR_W-1:0] base_addr,
`endif
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_send,
    input  logic              out_rdy,
    output logic              busy,
    output logic              empty,
    output logic              done
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] sz_q, issued, accepted, rd_ptr, first_addr;
    logic              inflight, xfer, room, last, fifo_empty, fifo_full;
    logic [1:0]        fifo_count;

`ifdef MM_FE_BASE_ADDR_EN
    assign first_addr = base_addr;
`else
    assign first_addr = '0;
`endif

    mm_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr      (inflight),
        .wdata   (ram_rdata),
        .rd      (xfer),
        .rdata   (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // A token leaving this cycle frees its slot, which keeps 1 token/cycle sustainable.
    always_comb begin
        out_send = !fifo_empty;
        xfer     = out_send && out_rdy;
        room     = xfer ? !(fifo_full && inflight) : ({1'b0, fifo_count} + {2'b0, inflight} < 3'd2);
        ram_en   = (state == RUN) && (issued != sz_q) && room;
        ram_addr = rd_ptr;
        last     = xfer && (accepted == sz_q - ADDR_W'(1));
        busy     = state == RUN;
        empty    = state == IDLE;
        state_n  = state == IDLE ? ((start && size != '0) ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            sz_q     <= '0;
            issued   <= '0;
            accepted <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            inflight <= ram_en;
            done     <= (state == RUN && last) || (state == IDLE && start && size == '0);
            if (state == IDLE && start) begin
                sz_q     <= size;
                issued   <= '0;
                accepted <= '0;
                rd_ptr   <= first_addr;
            end else begin
                if (ram_en) begin
                    issued <= issued + ADDR_W'(1);
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                if (xfer) accepted <= accepted + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mm_front_end.sv
// tb_mm_front_end: directed bench with a RAM model and address/token scoreboards.
module tb_mm_front_end;
    logic        aclk, aresetn, start, out_rdy;
    logic [9:0]  size, ram_addr;
    logic        ram_en, out_send, busy, empty, done;
    logic [31:0] ram_rdata, out_data;
`ifdef MM_FE_BASE_ADDR_EN
    logic [9:0]  base_addr;
`endif

    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];
    logic [9:0]  addr_q [$];
    int          checks = 0, errors = 0, acc_cnt = 0, outstanding = 0;
    logic        stall = 1'b0, xfer_s, seen;
    logic [31:0] stall_data;

    mm_front_end dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .size      (size),
`ifdef MM_FE_BASE_ADDR_EN
        .base_addr (base_addr),
`endif
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_send  (out_send),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .empty     (empty),
        .done      (done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) if (ram_en) ram_rdata <= mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [9:0] base, input int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic launch(input logic [9:0] n);
        start = 1'b1;
        size  = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (toggle) out_rdy = (c % 3 == 0);
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        out_rdy = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_out_send"}, 32'(out_send), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Port-level monitor: read order, token order, hold under stall, no read without room.
    always @(negedge aclk) begin
        if (!aresetn) begin
            outstanding = 0;
            stall       = 1'b0;
        end else begin
            xfer_s = out_send && out_rdy;
            if (stall) begin
                chk("hold_send", 32'(out_send), 32'd1);
                chk("hold_data", out_data, stall_data);
            end
            if (ram_en) begin
                chk("en_busy", 32'(busy), 32'd1);
                chk("en_room", 32'(outstanding - int'(xfer_s) < 2), 32'd1);
                if (addr_q.size() == 0) chk("spurious_en", 32'(ram_en), 32'd0);
                else chk("rd_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
            end
            if (xfer_s) begin
                if (exp_q.size() == 0) chk("spurious_tok", 32'(xfer_s), 32'd0);
                else chk("tok_data", out_data, exp_q.pop_front());
                acc_cnt++;
            end
            outstanding += int'(ram_en) - int'(xfer_s);
            stall      = out_send && !out_rdy;
            stall_data = out_data;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA0 + 32'(i);
        aresetn = 1'b0;
        start   = 1'b0;
        size    = '0;
        out_rdy = 1'b1;
`ifdef MM_FE_BASE_ADDR_EN
        base_addr = '0;
`endif
        tick();
        tick();
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        tick();

        // size 4, out_rdy high: issue 0..3 back to back, tokens from 2 cycles after start.
        push(10'd0, 4);
        acc_cnt = 0;
        launch(10'd4);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("t1_en", 32'(ram_en), 32'(i < 4));
            if (i < 4) chk("t1_addr", 32'(ram_addr), 32'(i));
            chk("t1_send", 32'(out_send), 32'(i >= 2));
            if (i >= 2) chk("t1_data", out_data, 32'hA0 + 32'(i - 2));
            tick();
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(empty), 32'd1);
        chk("t1_count", 32'(acc_cnt), 32'd4);

        // size 6 with out_rdy toggling 1,0,0
        push(10'd0, 6);
        acc_cnt = 0;
        launch(10'd6);
        wait_done(1'b1);
        chk("t2_count", 32'(acc_cnt), 32'd6);
        tick();

        // size 0: done next cycle, nothing issued or sent
        launch(10'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_en", 32'(ram_en), 32'd0);
        chk("t3_send", 32'(out_send), 32'd0);
        tick();
        chk("t3_done_pulse", 32'(done), 32'd0);
        chk("t3_send2", 32'(out_send), 32'd0);

        // restart while running is ignored
        push(10'd0, 3);
        acc_cnt = 0;
        launch(10'd3);
        launch(10'd8);
        wait_done(1'b0);
        chk("t4_count", 32'(acc_cnt), 32'd3);
        tick();
        chk("t4_idle", 32'(empty), 32'd1);

        // reset after 2 of 5 tokens, then a clean size-2 run
        push(10'd0, 5);
        acc_cnt = 0;
        launch(10'd5);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (acc_cnt >= 2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_two_accepted", 32'(seen), 32'd1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        exp_q.delete();
        addr_q.delete();
        tick();
        chk("t5_no_done", 32'(done), 32'd0);
        aresetn = 1'b1;
        tick();
        push(10'd0, 2);
        acc_cnt = 0;
        launch(10'd2);
        wait_done(1'b0);
        chk("t5_count", 32'(acc_cnt), 32'd2);
        tick();

`ifdef MM_FE_BASE_ADDR_EN
        // base address wraps modulo 2^10
        base_addr = 10'd1022;
        push(10'd1022, 4);
        acc_cnt = 0;
        launch(10'd4);
        wait_done(1'b0);
        chk("t6_count", 32'(acc_cnt), 32'd4);
        tick();
`endif

        chk("sb_tokens_left", 32'(exp_q.size()), 32'd0);
        chk("sb_addrs_left", 32'(addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
